// File: rtl/vend_pkg.sv
// Shared coin codes, default coin values and the controller state encoding.
// The REFUND state exists only when VEND_REFUND_EN is defined.
package vend_pkg;

    localparam logic [1:0] COIN_NONE     = 2'b00;
    localparam logic [1:0] COIN_CODE_LO  = 2'b01;
    localparam logic [1:0] COIN_CODE_HI  = 2'b10;
    localparam logic [1:0] COIN_CODE_TOP = 2'b11;

    localparam int COIN_LO_DEF  = 5;
    localparam int COIN_HI_DEF  = 10;
    localparam int COIN_TOP_DEF = 25;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
`ifdef VEND_REFUND_EN
        ST_VEND,
        ST_REFUND
`else
        ST_VEND
`endif
    } state_t;

endpackage

// File: rtl/vend_coin_dec.sv
// Maps a 2-bit coin code to its credit value; code 00 is worth nothing.
module vend_coin_dec
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 8,
    parameter int COIN_LO  = COIN_LO_DEF,
    parameter int COIN_HI  = COIN_HI_DEF,
    parameter int COIN_TOP = COIN_TOP_DEF
) (
    input  logic [1:0]          coin,
    output logic [CREDIT_W-1:0] value
);

    always_comb begin
        value = '0;
        case (coin)
            COIN_CODE_LO:  value = CREDIT_W'(COIN_LO);
            COIN_CODE_HI:  value = CREDIT_W'(COIN_HI);
            COIN_CODE_TOP: value = CREDIT_W'(COIN_TOP);
            default:       value = '0;
        endcase
    end

endmodule

// File: rtl/vend_ctrl.sv
// Vending controller: accumulates coin credit, vends with change, optional refund.
// Define VEND_REFUND_EN to enable the cancel/REFUND path.
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int                             N_PROD   = 4,
    parameter int                             CREDIT_W = 8,
    parameter logic [N_PROD*CREDIT_W-1:0]     PRICES   = 32'h1E19140F,
    parameter int                             COIN_LO  = COIN_LO_DEF,
    parameter int                             COIN_HI  = COIN_HI_DEF,
    parameter int                             COIN_TOP = COIN_TOP_DEF,
    parameter bit                             AUTO     = 1'b0,
    localparam int                            SEL_W    = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          coin,
    input  logic [SEL_W-1:0]    sel,
    input  logic                buy,
    input  logic                cancel,
    output logic                dispense,
    output logic [SEL_W-1:0]    disp_id,
    output logic [CREDIT_W-1:0] change,
    output logic                change_vld,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_rej,
    output logic                busy
);

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] change_q, change_d;
    logic [SEL_W-1:0]    disp_id_q, disp_id_d;
    logic                dispense_q, dispense_d;
    logic                change_vld_q, change_vld_d;
    logic                coin_rej_q, coin_rej_d;
    logic                busy_q, busy_d;

    logic [CREDIT_W-1:0] coin_val;
    logic [CREDIT_W:0]   sum;
    logic                overflow;
    logic [CREDIT_W-1:0] eff;
    logic [CREDIT_W-1:0] price;
    logic                sel_ok;

`ifndef VEND_REFUND_EN
    logic unused_cancel;
    assign unused_cancel = cancel;
`endif

    vend_coin_dec #(
        .CREDIT_W (CREDIT_W),
        .COIN_LO  (COIN_LO),
        .COIN_HI  (COIN_HI),
        .COIN_TOP (COIN_TOP)
    ) u_coin_dec (
        .coin  (coin),
        .value (coin_val)
    );

    // Out-of-range selections leave sel_ok low, so they can never vend.
    always_comb begin
        price  = '0;
        sel_ok = 1'b0;
        for (int i = 0; i < N_PROD; i++) begin
            if (sel == SEL_W'(i)) begin
                price  = PRICES[i*CREDIT_W +: CREDIT_W];
                sel_ok = 1'b1;
            end
        end
    end

    // An overflowing coin is dropped; the vend check then uses the held credit.
    always_comb begin
        sum      = {1'b0, credit_q} + {1'b0, coin_val};
        overflow = (coin != COIN_NONE) && sum[CREDIT_W];
        eff      = overflow ? credit_q : sum[CREDIT_W-1:0];
    end

    always_comb begin
        state_d      = state_q;
        credit_d     = credit_q;
        dispense_d   = 1'b0;
        disp_id_d    = '0;
        change_d     = '0;
        change_vld_d = 1'b0;
        coin_rej_d   = 1'b0;
        busy_d       = 1'b0;
        case (state_q)
            ST_IDLE, ST_ACCUM: begin
                coin_rej_d = overflow;
                if ((buy || AUTO) && sel_ok && (eff >= price)) begin
                    state_d      = ST_VEND;
                    dispense_d   = 1'b1;
                    disp_id_d    = sel;
                    change_d     = eff - price;
                    change_vld_d = 1'b1;
                    credit_d     = '0;
                    busy_d       = 1'b1;
                end
`ifdef VEND_REFUND_EN
                else if (cancel && (state_q == ST_ACCUM)) begin
                    state_d      = ST_REFUND;
                    change_d     = eff;
                    change_vld_d = 1'b1;
                    credit_d     = '0;
                    busy_d       = 1'b1;
                end
`endif
                else begin
                    credit_d = eff;
                    state_d  = (eff == '0) ? ST_IDLE : ST_ACCUM;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                credit_d   = '0;
                coin_rej_d = (coin != COIN_NONE);
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            credit_q     <= '0;
            change_q     <= '0;
            disp_id_q    <= '0;
            dispense_q   <= 1'b0;
            change_vld_q <= 1'b0;
            coin_rej_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            credit_q     <= credit_d;
            change_q     <= change_d;
            disp_id_q    <= disp_id_d;
            dispense_q   <= dispense_d;
            change_vld_q <= change_vld_d;
            coin_rej_q   <= coin_rej_d;
            busy_q       <= busy_d;
        end
    end

    assign dispense   = dispense_q;
    assign disp_id    = disp_id_q;
    assign change     = change_q;
    assign change_vld = change_vld_q;
    assign credit     = credit_q;
    assign coin_rej   = coin_rej_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Table-driven scoreboard bench for vend_ctrl, plus reset and AUTO sequences.
module tb_vend_ctrl;

    typedef struct {
        logic       dispense;
        logic [1:0] disp_id;
        logic [7:0] change;
        logic       change_vld;
        logic [7:0] credit;
        logic       coin_rej;
        logic       busy;
    } exp_t;

    typedef struct {
        logic [1:0] coin;
        logic [1:0] sel;
        logic       buy;
        logic       cancel;
        exp_t       e;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] coin = '0;
    logic [1:0] sel = '0;
    logic       buy = 1'b0;
    logic       cancel = 1'b0;
    logic       dispense, change_vld, coin_rej, busy;
    logic [1:0] disp_id;
    logic [7:0] change, credit;

    logic [1:0] coin_a = '0;
    logic [1:0] sel_a = '0;
    logic       buy_a = 1'b0;
    logic       cancel_a = 1'b0;
    logic       dispense_a, change_vld_a, coin_rej_a, busy_a;
    logic [1:0] disp_id_a;
    logic [7:0] change_a, credit_a;

    int n_cmp = 0;
    int n_fail = 0;
    vec_t tbl[$];
    exp_t exp_q[$];

    always #5 clk = ~clk;

    vend_ctrl u_dut (
        .clk(clk), .rst(rst), .coin(coin), .sel(sel), .buy(buy), .cancel(cancel),
        .dispense(dispense), .disp_id(disp_id), .change(change), .change_vld(change_vld),
        .credit(credit), .coin_rej(coin_rej), .busy(busy)
    );

    vend_ctrl #(.AUTO(1'b1)) u_auto (
        .clk(clk), .rst(rst), .coin(coin_a), .sel(sel_a), .buy(buy_a), .cancel(cancel_a),
        .dispense(dispense_a), .disp_id(disp_id_a), .change(change_a), .change_vld(change_vld_a),
        .credit(credit_a), .coin_rej(coin_rej_a), .busy(busy_a)
    );

    function automatic vec_t mk(input logic [1:0] c, input logic [1:0] s, input logic b,
                                input logic x, input logic d, input logic [1:0] id,
                                input logic [7:0] ch, input logic v, input logic [7:0] cr,
                                input logic rj, input logic bz);
        vec_t r;
        r.coin = c; r.sel = s; r.buy = b; r.cancel = x;
        r.e.dispense = d; r.e.disp_id = id; r.e.change = ch; r.e.change_vld = v;
        r.e.credit = cr; r.e.coin_rej = rj; r.e.busy = bz;
        return r;
    endfunction

    // Row with no vend/change activity: only credit and coin_rej matter.
    function automatic vec_t acc(input logic [1:0] c, input logic [1:0] s, input logic b,
                                 input logic x, input logic [7:0] cr, input logic rj);
        return mk(c, s, b, x, 1'b0, 2'd0, 8'd0, 1'b0, cr, rj, 1'b0);
    endfunction

    function automatic vec_t vnd(input logic [1:0] c, input logic [1:0] s, input logic x,
                                 input logic [7:0] ch);
        return mk(c, s, 1'b1, x, 1'b1, s, ch, 1'b1, 8'd0, 1'b0, 1'b1);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        exp_t e;
        @(negedge clk);
        coin = v.coin; sel = v.sel; buy = v.buy; cancel = v.cancel;
        exp_q.push_back(v.e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk($sformatf("v%0d.dispense", idx), 32'(dispense), 32'(e.dispense));
        chk($sformatf("v%0d.disp_id", idx), 32'(disp_id), 32'(e.disp_id));
        chk($sformatf("v%0d.change", idx), 32'(change), 32'(e.change));
        chk($sformatf("v%0d.change_vld", idx), 32'(change_vld), 32'(e.change_vld));
        chk($sformatf("v%0d.credit", idx), 32'(credit), 32'(e.credit));
        chk($sformatf("v%0d.coin_rej", idx), 32'(coin_rej), 32'(e.coin_rej));
        chk($sformatf("v%0d.busy", idx), 32'(busy), 32'(e.busy));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // three 5-coins then buy product 0 (price 15)
        tbl.push_back(acc(2'd1, 2'd0, 0, 0, 8'd5, 0));
        tbl.push_back(acc(2'd1, 2'd0, 0, 0, 8'd10, 0));
        tbl.push_back(acc(2'd1, 2'd0, 0, 0, 8'd15, 0));
        tbl.push_back(vnd(2'd0, 2'd0, 0, 8'd0));
        tbl.push_back(acc(2'd0, 2'd0, 0, 0, 8'd0, 0));
        // two 10-coins, buy product 0
        tbl.push_back(acc(2'd2, 2'd0, 0, 0, 8'd10, 0));
        tbl.push_back(acc(2'd2, 2'd0, 0, 0, 8'd20, 0));
        tbl.push_back(vnd(2'd0, 2'd0, 0, 8'd5));
        tbl.push_back(acc(2'd0, 2'd0, 0, 0, 8'd0, 0));
        // insufficient credit for product 1, then coin+buy on one edge
        tbl.push_back(acc(2'd2, 2'd0, 0, 0, 8'd10, 0));
        tbl.push_back(acc(2'd0, 2'd1, 1, 0, 8'd10, 0));
        tbl.push_back(acc(2'd0, 2'd1, 0, 0, 8'd10, 0));
        tbl.push_back(vnd(2'd2, 2'd1, 0, 8'd0));
        tbl.push_back(acc(2'd3, 2'd0, 0, 0, 8'd0, 1));
        tbl.push_back(acc(2'd0, 2'd0, 0, 0, 8'd0, 0));
        // product 3
        tbl.push_back(acc(2'd3, 2'd0, 0, 0, 8'd25, 0));
        tbl.push_back(vnd(2'd2, 2'd3, 0, 8'd5));
        tbl.push_back(acc(2'd0, 2'd0, 0, 0, 8'd0, 0));
        // credit saturation: eleventh 25-coin rejected
        for (int k = 1; k <= 10; k++) tbl.push_back(acc(2'd3, 2'd0, 0, 0, 8'(25 * k), 0));
        tbl.push_back(acc(2'd3, 2'd0, 0, 0, 8'd250, 1));
        tbl.push_back(acc(2'd0, 2'd0, 0, 0, 8'd250, 0));
        tbl.push_back(vnd(2'd0, 2'd3, 0, 8'd220));
        tbl.push_back(acc(2'd0, 2'd0, 0, 0, 8'd0, 0));
        // buy wins over cancel
        tbl.push_back(acc(2'd3, 2'd0, 0, 0, 8'd25, 0));
        tbl.push_back(vnd(2'd0, 2'd0, 1, 8'd10));
        tbl.push_back(acc(2'd0, 2'd0, 0, 0, 8'd0, 0));
`ifdef VEND_REFUND_EN
        tbl.push_back(acc(2'd0, 2'd0, 0, 1, 8'd0, 0));
        tbl.push_back(acc(2'd2, 2'd0, 0, 0, 8'd10, 0));
        tbl.push_back(acc(2'd1, 2'd0, 0, 0, 8'd15, 0));
        tbl.push_back(mk(2'd0, 2'd0, 0, 1, 1'b0, 2'd0, 8'd15, 1'b1, 8'd0, 1'b0, 1'b1));
        tbl.push_back(acc(2'd0, 2'd0, 0, 0, 8'd0, 0));
`else
        tbl.push_back(acc(2'd2, 2'd0, 0, 0, 8'd10, 0));
        tbl.push_back(acc(2'd0, 2'd0, 0, 1, 8'd10, 0));
        tbl.push_back(vnd(2'd1, 2'd0, 0, 8'd0));
        tbl.push_back(acc(2'd0, 2'd0, 0, 0, 8'd0, 0));
`endif

        #12;
        chk("rst.dispense", 32'(dispense), 32'd0);
        chk("rst.change_vld", 32'(change_vld), 32'd0);
        chk("rst.credit", 32'(credit), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

        // asynchronous reset while in VEND
        run_vec(acc(2'd1, 2'd0, 0, 0, 8'd5, 0), 100);
        run_vec(acc(2'd1, 2'd0, 0, 0, 8'd10, 0), 101);
        run_vec(acc(2'd1, 2'd0, 0, 0, 8'd15, 0), 102);
        run_vec(vnd(2'd0, 2'd0, 0, 8'd0), 103);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst.dispense", 32'(dispense), 32'd0);
        chk("midrst.change_vld", 32'(change_vld), 32'd0);
        chk("midrst.credit", 32'(credit), 32'd0);
        chk("midrst.busy", 32'(busy), 32'd0);
        @(negedge clk);
        buy = 1'b0;
        rst = 1'b1;
        run_vec(acc(2'd1, 2'd0, 0, 0, 8'd5, 0), 104);
        run_vec(acc(2'd0, 2'd0, 0, 1, 8'd5, 0), 105);

        // AUTO instance: 10 then 25 on product 2 (price 25)
        @(negedge clk);
        coin = 2'd0; buy = 1'b0; cancel = 1'b0;
        coin_a = 2'd2; sel_a = 2'd2;
        @(posedge clk);
        #1;
        chk("auto1.dispense", 32'(dispense_a), 32'd0);
        chk("auto1.credit", 32'(credit_a), 32'd10);
        @(negedge clk);
        coin_a = 2'd3;
        @(posedge clk);
        #1;
        chk("auto2.dispense", 32'(dispense_a), 32'd1);
        chk("auto2.disp_id", 32'(disp_id_a), 32'd2);
        chk("auto2.change", 32'(change_a), 32'd10);
        chk("auto2.change_vld", 32'(change_vld_a), 32'd1);
        chk("auto2.credit", 32'(credit_a), 32'd0);
        @(negedge clk);
        coin_a = 2'd0;
        @(posedge clk);
        #1;
        chk("auto3.dispense", 32'(dispense_a), 32'd0);
        chk("auto3.busy", 32'(busy_a), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
